// File: rtl/sfq_splitter_tree_clk.sv
`default_nettype none
// ============================================================================
// Module      : sfq_splitter_tree_clk
// Description : Clocked SFQ splitter tree. Accepts one toggle-encoded pulse
//               stream, stores pulses in a small flux-storage counter and
//               re-emits them on NOUT toggle-encoded outputs, either as a
//               broadcast to every enabled output or round-robin to one
//               enabled output per issue.
//               Optional macro SFQ_PULSE_STATS_EN adds saturating 16-bit
//               issued/dropped pulse counters as extra output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_splitter_tree_clk #(
  parameter int NOUT  = 4,   // number of outputs, 2..16
  parameter int DEPTH = 1,   // maximum stored pulses, 1..15
  parameter int CW    = 4    // pending counter width, 2**CW > DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in,
  input  logic            mode,
  input  logic [NOUT-1:0] en_mask,
  output logic [NOUT-1:0] out,
  output logic [CW-1:0]   pending,
`ifdef SFQ_PULSE_STATS_EN
  output logic            overflow,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     dropped_cnt
`else
  output logic            overflow
`endif
);

  // Pointer width: enough bits to name every output.
  localparam int PW = (NOUT > 1) ? $clog2(NOUT) : 1;

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [PW:0]   C_NOUT     = (PW+1)'(NOUT);
  localparam logic [PW-1:0] C_LAST_IDX = PW'(NOUT - 1);
  localparam logic [NOUT-1:0] C_BIT0   = {{(NOUT-1){1'b0}}, 1'b1};

  // Sampled copy of the input level; a difference marks one pulse.
  logic            in_q;
  // Round-robin pointer: the first output considered at the next issue.
  logic [PW-1:0]   ptr;

  logic            acc;        // a pulse arrived this cycle
  logic            iss;        // a stored pulse is emitted this cycle
  logic            full;       // counter is at DEPTH
  logic            drop;       // arriving pulse cannot be stored
  logic [PW-1:0]   rr_idx;     // round-robin target output
  logic [PW-1:0]   rr_next;    // pointer value after serving rr_idx
  logic [NOUT-1:0] rr_onehot;  // toggle vector for round-robin issue
  logic [NOUT-1:0] toggle_vec; // outputs that change level this cycle
  logic [CW-1:0]   pending_nx;

  // Pulse detection and issue/drop decisions from pre-edge state.
  always_comb begin
    acc  = in ^ in_q;
    iss  = (pending != '0) && (|en_mask);
    full = (pending == C_DEPTH);
    drop = acc && !iss && full;
  end

  // Round-robin search: first enabled output at or after ptr, wrapping.
  always_comb begin
    logic         found;
    logic [PW:0]  cand;
    found  = 1'b0;
    cand   = '0;
    rr_idx = ptr;
    for (int k = 0; k < NOUT; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= C_NOUT) begin
        cand = cand - C_NOUT;
      end
      if (!found && en_mask[cand[PW-1:0]]) begin
        found  = 1'b1;
        rr_idx = cand[PW-1:0];
      end
    end
  end

  // Next pointer and the one-hot toggle for the round-robin target.
  always_comb begin
    rr_next   = (rr_idx == C_LAST_IDX) ? '0 : (rr_idx + PW'(1));
    rr_onehot = C_BIT0 << rr_idx;
  end

  // Which outputs toggle: all enabled ones (broadcast) or one target.
  always_comb begin
    toggle_vec = '0;
    if (iss) begin
      toggle_vec = mode ? rr_onehot : en_mask;
    end
  end

  // Pending counter arithmetic; an accept that coincides with an issue nets zero.
  always_comb begin
    pending_nx = pending;
    if (acc && !iss && !full) begin
      pending_nx = pending + C_ONE;
    end else if (!acc && iss) begin
      pending_nx = pending - C_ONE;
    end
  end

  // Core state: input sample, outputs, counter, pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= 1'b0;
      out      <= '0;
      pending  <= '0;
      ptr      <= '0;
      overflow <= 1'b0;
    end else begin
      in_q    <= in;
      out     <= out ^ toggle_vec;
      pending <= pending_nx;
      if (iss && mode) begin
        ptr <= rr_next;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SFQ_PULSE_STATS_EN
  // Saturating statistics: one count per issue cycle and per dropped pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (iss && (issued_cnt != 16'hFFFF)) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
      if (drop && (dropped_cnt != 16'hFFFF)) begin
        dropped_cnt <= dropped_cnt + 16'd1;
      end
    end
  end
`else
  // Without statistics there is no extra state; the decisions above suffice.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sfq_splitter_tree_clk.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfq_splitter_tree_clk
// Description : Self-checking bench for sfq_splitter_tree_clk with a
//               pulse-count reference model, directed scenarios and a
//               randomized phase including asynchronous mid-run resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfq_splitter_tree_clk;

  localparam int NOUT  = 4;
  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            din = 1'b0;
  logic            mode = 1'b0;
  logic [NOUT-1:0] en_mask = '0;
  logic [NOUT-1:0] out;
  logic [CW-1:0]   pending;
  logic            overflow;
`ifdef SFQ_PULSE_STATS_EN
  logic [15:0]     issued_cnt;
  logic [15:0]     dropped_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: stored pulse count, pointer, output levels.
  logic            m_in_q;
  int              m_pend;
  int              m_ptr;
  logic [NOUT-1:0] m_out;
  logic            m_ovf;
  int              m_issued;
  int              m_dropped;

  sfq_splitter_tree_clk #(
    .NOUT (NOUT),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .mode       (mode),
    .en_mask    (en_mask),
    .out        (out),
    .pending    (pending),
`ifdef SFQ_PULSE_STATS_EN
    .overflow   (overflow),
    .issued_cnt (issued_cnt),
    .dropped_cnt(dropped_cnt)
`else
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_q    = 1'b0;
    m_pend    = 0;
    m_ptr     = 0;
    m_out     = '0;
    m_ovf     = 1'b0;
    m_issued  = 0;
    m_dropped = 0;
  endtask

  // One rising edge of the reference: count pulses, hand them out.
  task automatic model_edge();
    bit acc;
    bit iss;
    acc    = (din != m_in_q);
    m_in_q = din;
    iss    = (m_pend > 0) && (en_mask != 0);
    if (iss) begin
      if (m_issued < 65535) m_issued++;
      if (!mode) begin
        m_out = m_out ^ en_mask;
      end else begin
        for (int k = 0; k < NOUT; k++) begin
          int j;
          j = (m_ptr + k) % NOUT;
          if (en_mask[j]) begin
            m_out[j] = ~m_out[j];
            m_ptr    = (j + 1) % NOUT;
            break;
          end
        end
      end
    end
    if (acc && !iss) begin
      if (m_pend < DEPTH) begin
        m_pend++;
      end else begin
        m_ovf = 1'b1;
        if (m_dropped < 65535) m_dropped++;
      end
    end else if (!acc && iss) begin
      m_pend--;
    end
  endtask

  task automatic compare_all();
    check_value("out", 32'(out), 32'(m_out));
    check_value("pending", 32'(pending), 32'(m_pend));
    check_value("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SFQ_PULSE_STATS_EN
    check_value("issued_cnt", 32'(issued_cnt), 32'(m_issued));
    check_value("dropped_cnt", 32'(dropped_cnt), 32'(m_dropped));
`endif
  endtask

  // Advance one clock, update the model, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse();
    din = ~din;
    step();
  endtask

  // Asynchronous reset asserted away from the edge, held across one edge.
  task automatic do_reset();
    din = 1'b0;
    rst = 1'b1;
    #1;
    check_value("rst_out", 32'(out), 32'h0);
    check_value("rst_pending", 32'(pending), 32'h0);
    check_value("rst_overflow", 32'(overflow), 32'h0);
`ifdef SFQ_PULSE_STATS_EN
    check_value("rst_issued", 32'(issued_cnt), 32'h0);
    check_value("rst_dropped", 32'(dropped_cnt), 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Single pulse broadcast to all four outputs.
    do_reset();
    mode = 1'b0; en_mask = 4'b1111;
    pulse();
    check_value("t1_pending", 32'(pending), 32'd1);
    check_value("t1_out0", 32'(out), 32'h0);
    step();
    check_value("t1_out", 32'(out), 32'hF);
    check_value("t1_pending0", 32'(pending), 32'd0);
    check_value("t1_ovf", 32'(overflow), 32'd0);

    // Broadcast to a sparse mask, three spaced pulses.
    do_reset();
    mode = 1'b0; en_mask = 4'b0101;
    for (int p = 0; p < 3; p++) begin
      pulse(); step(); step();
    end
    check_value("t2_out", 32'(out), 32'h5);

    // Round-robin over mask 1011: targets 0,1,3,0,1, then 3 again.
    do_reset();
    mode = 1'b1; en_mask = 4'b1011;
    for (int p = 0; p < 5; p++) begin
      pulse(); step(); step();
    end
    check_value("t3_out", 32'(out), 32'h8);
    pulse(); step();
    check_value("t3_ptr_wrap", 32'(out), 32'h0);

    // Overflow with no outputs enabled, then drain.
    do_reset();
    mode = 1'b0; en_mask = 4'b0000;
    pulse(); pulse(); pulse();
    check_value("t4_pending", 32'(pending), 32'd2);
    check_value("t4_ovf", 32'(overflow), 32'd1);
    en_mask = 4'b0001;
    step();
    check_value("t4_out_a", 32'(out), 32'h1);
    step();
    check_value("t4_out_b", 32'(out), 32'h0);
    check_value("t4_pending0", 32'(pending), 32'd0);
    check_value("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Accept and issue on the same edge while full: no overflow.
    do_reset();
    mode = 1'b0; en_mask = 4'b0000;
    pulse(); pulse();
    en_mask = 4'b0001;
    pulse();
    check_value("t5_pending", 32'(pending), 32'd2);
    check_value("t5_ovf", 32'(overflow), 32'd0);
    check_value("t5_out", 32'(out), 32'h1);

    // Reset mid-operation with stored pulses and non-zero outputs.
    do_reset();
    mode = 1'b0; en_mask = 4'b1111;
    pulse(); step();
    en_mask = 4'b0000;
    pulse(); pulse();
    check_value("t6_pre_pending", 32'(pending), 32'd2);
    #2;
    do_reset();
    en_mask = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    check_value("t6_quiet", 32'(out), 32'h0);

    // Randomized traffic, mode and mask changes, occasional async reset.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) en_mask = '0;
        else en_mask = NOUT'($urandom);
      end
      if ($urandom_range(0, 9) < 4) din = ~din;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire

// File: doc/sfq_splitter_tree_clk.md
Name: sfq_splitter_tree_clk

Overview:
- Clocked, parametrised successor to the single-input, two-output SFQ splitter model.
- Takes one toggle-encoded SFQ pulse stream, where every level change of `in` is one pulse.
- Buffers pulses in a small flux-storage counter and re-emits them on NOUT toggle-encoded outputs, aligned to `clk`.
- Two distribution modes: broadcast (fan-out) and round-robin (pulse demux). Sits between clock-less pulse cells and clocked logic in system-level timing benches.

Parameters:
- NOUT, 4: number of outputs, 2..16.
- DEPTH, 1: maximum pending pulses stored, 1..15. DEPTH=1 models single-quantum storage.
- CW, 4: pending-counter width; must satisfy 2**CW > DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  toggle-encoded pulse input; each level change is one pulse.
- mode  input  1  0 = broadcast, 1 = round-robin; sampled every cycle.
- en_mask  input  NOUT  per-output enable; bit i enables out[i].
- out  output  NOUT  toggle-encoded pulse outputs; a pulse on out[i] is a level change of out[i].
- pending  output  CW  current number of stored pulses.
- overflow  output  1  sticky flag, set when a pulse is dropped.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - out=0, pending=0, overflow=0, round-robin pointer ptr=0, in_q=0.
  - After release, `in`=1 on the first edge counts as one pulse. Benches must hold `in`=0 through reset.
- Pulse detect: at each rising edge, acc = (in != in_q), then in_q <= in. At most one pulse is recognised per cycle. A double toggle within one cycle is invisible (documented limitation).
- Issue condition: iss = (pending > 0) && (en_mask != 0). The issue decision uses the pre-edge pending value, so there is no same-cycle bypass.
- Latency: a pulse accepted at edge k with pending=0 appears on out at edge k+1.
- Counter update at each edge:
  - acc && !iss, pending < DEPTH: pending+1.
  - acc && !iss, pending == DEPTH: pulse dropped, overflow <= 1, pending unchanged.
  - !acc && iss: pending-1.
  - acc && iss: pending unchanged. This is never an overflow, even when full.
  - Neither: hold.
- Broadcast (mode=0), on iss: out[i] toggles for every i with en_mask[i]=1; ptr unchanged.
- Round-robin (mode=1), on iss:
  - Target j = first index with en_mask[j]=1, searching ptr, ptr+1, …, wrapping modulo NOUT.
  - out[j] toggles and ptr <= (j+1) mod NOUT.
  - Exactly one output toggles per issue.
- en_mask == 0: no issue; pulses stay pending (subject to overflow); ptr held.
- Mode or en_mask changes take effect on the same edge they are sampled. ptr is preserved across mode switches.
- overflow clears only on reset.
- rst asserted mid-operation: stored pulses are discarded and no output toggles at release.

Optional Feature:
- Macro SFQ_PULSE_STATS_EN.
- When defined:
  - Adds output ports issued_cnt [15:0] and dropped_cnt [15:0], both reset to 0.
  - issued_cnt increments once per iss cycle, regardless of how many outputs toggle.
  - dropped_cnt increments once per dropped pulse.
  - Both saturate at 16'hFFFF.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then NOUT=4, DEPTH=1, mode=0, en_mask=4'b1111, one toggle on `in` -> at the next edge pending=1; at the following edge out=4'b1111, pending=0, overflow=0.
- Broadcast with en_mask=4'b0101, three pulses spaced 3 cycles apart -> out[0] and out[2] each toggle 3 times, ending at 1; out[1] and out[3] stay 0.
- Round-robin with en_mask=4'b1011, 5 spaced pulses -> targets in order 0,1,3,0,1; final out=4'b1000 ^ 4'b0001 ^ … = out[0]=0, out[1]=0, out[3]=1; ptr=2.
- Overflow at DEPTH=2: en_mask=0, 3 pulses -> pending=2, overflow=1. Then en_mask=4'b0001 -> out[0] toggles twice over 2 cycles, pending=0, overflow stays 1.
- Simultaneous accept+issue at DEPTH=1: pending=1, new pulse on the same edge an issue occurs -> pending stays 1, overflow=0.
- Reset mid-operation with pending=2 -> pending=0 and out=0 immediately (asynchronous); no toggles after release. With SFQ_PULSE_STATS_EN defined, issued_cnt and dropped_cnt read 0.
